// File: rtl/cpu_net_core_if.sv
// Bus bundle between the core and its ROM / data-memory / scan-test environment.
// Carries the instruction fetch, scan controls and all registered core outputs.
// The core side takes the slave modport; the driving environment takes master.
interface cpu_net_core_if;
  logic [7:0] inst;
  logic       scan_en;
  logic       scan_in;
  logic [7:0] pc_out;
  logic [7:0] address_out;
  logic [7:0] out_data_out;
  logic       store_out;
  logic       scan_out;

  modport master (
    output inst, scan_en, scan_in,
    input  pc_out, address_out, out_data_out, store_out, scan_out
  );

  modport slave (
    input  inst, scan_en, scan_in,
    output pc_out, address_out, out_data_out, store_out, scan_out
  );
endinterface

// File: rtl/cpu_net_core.sv
// 8-bit single-cycle CPU core with a full 57-flop scan chain over all state.
// Latency: one instruction retires per clk; all outputs come straight from flops.
// No backpressure: the core executes or shifts every cycle unconditionally.
module cpu_net_core (
  input  logic         clk,
  input  logic         rst,
  cpu_net_core_if.slave bus
);
  localparam int DW        = 8;
  localparam int CHAIN_LEN = 57;

  // architectural state
  logic [DW-1:0] pc;
  logic [DW-1:0] regs [4];
  logic [DW-1:0] addr;
  logic [DW-1:0] dout;
  logic          store_q;

  // next-state values for functional execution
  logic [DW-1:0] pc_nxt;
  logic [DW-1:0] regs_nxt [4];
  logic [DW-1:0] addr_nxt;
  logic [DW-1:0] dout_nxt;
  logic          store_nxt;

  // instruction fields and operands (pre-edge register values)
  logic [1:0]    op;
  logic [1:0]    ra_sel;
  logic [1:0]    rb_sel;
  logic [1:0]    fn;
  logic [DW-1:0] ra;
  logic [DW-1:0] rb;
  logic [DW-1:0] pc_inc;

  // chain contents after one shift: scan_in enters at PC[7], store_q falls off the end
  logic [CHAIN_LEN-1:0] shifted;

  assign op     = bus.inst[7:6];
  assign ra_sel = bus.inst[5:4];
  assign rb_sel = bus.inst[3:2];
  assign fn     = bus.inst[1:0];
  assign ra     = regs[ra_sel];
  assign rb     = regs[rb_sel];
  assign pc_inc = pc + 8'd1;

  assign shifted = {bus.scan_in, pc, regs[0], regs[1], regs[2], regs[3], addr, dout};

  // decode and execute the current instruction
  always_comb begin
    pc_nxt    = pc_inc;
    addr_nxt  = addr;
    dout_nxt  = dout;
    store_nxt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      regs_nxt[i] = regs[i];
    end

    case (op)
      2'b00: begin
        case (fn)
          2'b00:   regs_nxt[ra_sel] = ra + rb;
          2'b01:   regs_nxt[ra_sel] = ra - rb;
          2'b10:   regs_nxt[ra_sel] = ra & rb;
          default: regs_nxt[ra_sel] = ra ^ rb;
        endcase
      end
      2'b01: begin
        regs_nxt[ra_sel] = {4'b0000, bus.inst[3:0]};
      end
      2'b10: begin
        // a==b is legal: both ports read the same pre-edge value
        addr_nxt  = ra;
        dout_nxt  = rb;
        store_nxt = 1'b1;
      end
      default: begin
        case (fn)
          2'b00:   pc_nxt = ra;
          2'b01:   pc_nxt = (rb == 8'h00) ? ra : pc_inc;
          2'b10:   regs_nxt[ra_sel] = {ra[DW-2:0], 1'b0};
          default: pc_nxt = pc_inc;
        endcase
      end
    endcase
  end

  // state update: reset beats scan shift, scan shift beats execution
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= '0;
      addr    <= '0;
      dout    <= '0;
      store_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        regs[i] <= '0;
      end
    end else if (bus.scan_en) begin
      {pc, regs[0], regs[1], regs[2], regs[3], addr, dout, store_q} <= shifted;
    end else begin
      pc      <= pc_nxt;
      addr    <= addr_nxt;
      dout    <= dout_nxt;
      store_q <= store_nxt;
      for (int i = 0; i < 4; i++) begin
        regs[i] <= regs_nxt[i];
      end
    end
  end

  assign bus.pc_out       = pc;
  assign bus.address_out  = addr;
  assign bus.out_data_out = dout;
  assign bus.store_out    = store_q;
  assign bus.scan_out     = store_q;
endmodule

// File: tb/tb_cpu_net_core.sv
// Bench for cpu_net_core: directed vector table, scan-chain sequences, random run.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// Reference model holds architectural state as plain variables and applies the ISA rules.
module tb_cpu_net_core;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cpu_net_core_if bus ();

  cpu_net_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [7:0] m_pc, m_addr, m_dout;
  logic [7:0] m_r [4];
  logic       m_st;

  typedef struct {
    logic       r;
    logic [7:0] ins;
    logic [7:0] pc;
    logic [7:0] addr;
    logic [7:0] dout;
    logic       st;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(logic r, logic [7:0] ins, logic [7:0] pc,
                              logic [7:0] addr, logic [7:0] dout, logic st);
    vec_t v;
    v.r = r; v.ins = ins; v.pc = pc; v.addr = addr; v.dout = dout; v.st = st;
    return v;
  endfunction

  // model state in scan order, bit 56 = PC[7] ... bit 0 = store flag
  function automatic logic [56:0] pack_model();
    return {m_pc, m_r[0], m_r[1], m_r[2], m_r[3], m_addr, m_dout, m_st};
  endfunction

  task automatic model_step(input logic r, input logic se, input logic si, input logic [7:0] ins);
    logic [56:0] v;
    logic [1:0]  op, a, b, f;
    logic [7:0]  x, y, npc;
    if (r) begin
      m_pc = 0; m_addr = 0; m_dout = 0; m_st = 0;
      for (int i = 0; i < 4; i++) m_r[i] = 0;
    end else if (se) begin
      v = pack_model();
      v = {si, v[56:1]};
      {m_pc, m_r[0], m_r[1], m_r[2], m_r[3], m_addr, m_dout, m_st} = v;
    end else begin
      op = ins[7:6]; a = ins[5:4]; b = ins[3:2]; f = ins[1:0];
      x = m_r[a]; y = m_r[b];
      npc  = m_pc + 8'd1;
      m_st = 0;
      if (op == 0)
        m_r[a] = (f == 0) ? x + y : (f == 1) ? x - y : (f == 2) ? (x & y) : (x ^ y);
      else if (op == 1)
        m_r[a] = ins & 8'h0F;
      else if (op == 2) begin
        m_addr = x; m_dout = y; m_st = 1;
      end else begin
        if (f == 0) npc = x;
        else if (f == 1 && y == 0) npc = x;
        else if (f == 2) m_r[a] = x * 8'd2;
      end
      m_pc = npc;
    end
  endtask

  task automatic step(input logic r, input logic se, input logic si, input logic [7:0] ins);
    @(negedge clk);
    rst         = r;
    bus.scan_en = se;
    bus.scan_in = si;
    bus.inst    = ins;
    @(posedge clk);
    #1;
    model_step(r, se, si, ins);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"},    bus.pc_out,              m_pc);
    check({tag, ".addr"},  bus.address_out,         m_addr);
    check({tag, ".dout"},  bus.out_data_out,        m_dout);
    check({tag, ".store"}, {7'd0, bus.store_out},   {7'd0, m_st});
    check({tag, ".scan"},  {7'd0, bus.scan_out},    {7'd0, m_st});
  endtask

  initial begin
    logic [56:0] v_prior;
    logic [56:0] pat;

    tbl[0]  = mk(1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    tbl[1]  = mk(0, 8'h55, 8'h01, 8'h00, 8'h00, 0);
    tbl[2]  = mk(0, 8'h63, 8'h02, 8'h00, 8'h00, 0);
    tbl[3]  = mk(0, 8'h18, 8'h03, 8'h00, 8'h00, 0);
    tbl[4]  = mk(0, 8'hA4, 8'h04, 8'h03, 8'h08, 1);
    tbl[5]  = mk(0, 8'hC3, 8'h05, 8'h03, 8'h08, 0);
    tbl[6]  = mk(1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    tbl[7]  = mk(0, 8'h71, 8'h01, 8'h00, 8'h00, 0);
    tbl[8]  = mk(0, 8'h0D, 8'h02, 8'h00, 8'h00, 0);
    tbl[9]  = mk(0, 8'hC2, 8'h03, 8'h00, 8'h00, 0);
    tbl[10] = mk(0, 8'h80, 8'h04, 8'hFE, 8'hFE, 1);
    tbl[11] = mk(1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    tbl[12] = mk(0, 8'h59, 8'h01, 8'h00, 8'h00, 0);
    tbl[13] = mk(0, 8'hD1, 8'h09, 8'h00, 8'h00, 0);
    tbl[14] = mk(1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    tbl[15] = mk(0, 8'h41, 8'h01, 8'h00, 8'h00, 0);
    tbl[16] = mk(0, 8'hD1, 8'h02, 8'h00, 8'h00, 0);
    tbl[17] = mk(0, 8'h6F, 8'h03, 8'h00, 8'h00, 0);
    tbl[18] = mk(0, 8'hE0, 8'h0F, 8'h00, 8'h00, 0);
    tbl[19] = mk(0, 8'h84, 8'h10, 8'h01, 8'h00, 1);
    tbl[20] = mk(0, 8'h98, 8'h11, 8'h00, 8'h0F, 1);
    tbl[21] = mk(0, 8'h0A, 8'h12, 8'h00, 8'h0F, 0);
    tbl[22] = mk(0, 8'h2B, 8'h13, 8'h00, 8'h0F, 0);
    tbl[23] = mk(0, 8'h88, 8'h14, 8'h01, 8'h00, 1);

    rst = 1'b1; bus.scan_en = 1'b0; bus.scan_in = 1'b0; bus.inst = 8'h00;

    // initial reset
    step(1, 0, 0, 8'h00);
    check("rst.pc",    bus.pc_out,            8'h00);
    check("rst.addr",  bus.address_out,       8'h00);
    check("rst.dout",  bus.out_data_out,      8'h00);
    check("rst.store", {7'd0, bus.store_out}, 8'h00);
    check("rst.scan",  {7'd0, bus.scan_out},  8'h00);

    // load random state through the chain so the table's first reset starts from it
    for (int k = 0; k < 57; k++) begin
      step(0, 1, 1'($urandom), 8'($urandom));
      check_model("rndscan");
    end

    // directed instruction vectors
    for (int i = 0; i < 24; i++) begin
      step(tbl[i].r, 0, 0, tbl[i].ins);
      check($sformatf("vec%0d.pc", i),    bus.pc_out,            tbl[i].pc);
      check($sformatf("vec%0d.addr", i),  bus.address_out,       tbl[i].addr);
      check($sformatf("vec%0d.dout", i),  bus.out_data_out,      tbl[i].dout);
      check($sformatf("vec%0d.store", i), {7'd0, bus.store_out}, {7'd0, tbl[i].st});
    end

    // scan unload/load: prior state streams out in chain order, pattern lands in fields
    v_prior = pack_model();
    pat     = {8'hFF, 17'($urandom), 32'($urandom)};
    check("scan_stream0", {7'd0, bus.scan_out}, {7'd0, v_prior[0]});
    for (int k = 0; k < 57; k++) begin
      step(0, 1, pat[k], 8'($urandom));
      if (k < 56)
        check($sformatf("scan_stream%0d", k + 1), {7'd0, bus.scan_out}, {7'd0, v_prior[k + 1]});
    end
    check("scan_ld.pc",    bus.pc_out,            pat[56:49]);
    check("scan_ld.addr",  bus.address_out,       pat[16:9]);
    check("scan_ld.dout",  bus.out_data_out,      pat[8:1]);
    check("scan_ld.store", {7'd0, bus.store_out}, {7'd0, pat[0]});
    step(0, 0, 0, 8'hC3);
    check("pc_wrap", bus.pc_out, 8'h00);
    check("pc_wrap.store", {7'd0, bus.store_out}, 8'h00);

    // reset asserted mid-scan, with scan_en still high
    for (int k = 0; k < 10; k++) step(0, 1, 1'b1, 8'h00);
    step(1, 1, 1'b1, 8'hA4);
    check("midscan_rst.pc",    bus.pc_out,            8'h00);
    check("midscan_rst.addr",  bus.address_out,       8'h00);
    check("midscan_rst.dout",  bus.out_data_out,      8'h00);
    check("midscan_rst.scan",  {7'd0, bus.scan_out},  8'h00);

    // randomized run against the reference model
    for (int n = 0; n < 2000; n++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
           1'($urandom), 8'($urandom));
      check_model("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
